// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RISC-V core: fetch/decode/execute/memory/writeback sequencing.
// Optional MULTICYCLE_ILLEGAL_TRAP_EN makes unknown opcodes enter a sticky TRAP state.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic             pc_update,
  output logic             branch,
  output logic             reg_write,
  output logic             mem_write,
  output logic             ir_write,
  output logic             adr_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             illegal_op
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_JAL      = 4'd8,
    S_ALUWB    = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             retire_c;
  logic             pc_update_c, branch_c, reg_write_c, mem_write_c, ir_write_c;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic             illegal_c;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d     = state_q;
    retire_c    = 1'b0;
    pc_update_c = 1'b0;
    branch_c    = 1'b0;
    reg_write_c = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;
    result_src  = 2'b00;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    illegal_c   = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        alu_src_b   = 2'b10;
        result_src  = 2'b10;
        ir_write_c  = mem_ready;
        pc_update_c = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        if (mem_ready) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        pc_update_c = 1'b1;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch_c  = 1'b1;
        retire_c  = 1'b1;
        state_d   = S_FETCH;
      end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP: begin
        illegal_c = 1'b1;
        state_d   = S_TRAP;
      end
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // Retired-instruction counter; wraps naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        instret_q <= '0;
    else if (retire_c) instret_q <= instret_q + CNT_W'(1);
  end

  // Write enables are held off while reset is asserted
  assign pc_update = reset & pc_update_c;
  assign branch    = reset & branch_c;
  assign reg_write = reset & reg_write_c;
  assign mem_write = reset & mem_write_c;
  assign ir_write  = reset & ir_write_c;
  assign state     = 4'(state_q);
  assign instret   = instret_q;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign illegal_op = reset & illegal_c;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (CNT_W=4 so the instret wrap is reachable).
module tb_multicycle_ctrl;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       mem_ready;
  logic       pc_update, branch, reg_write, mem_write, ir_write, adr_src, illegal_op;
  logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
  logic [3:0] state;
  logic [3:0] instret;

  int checks = 0;
  int errors = 0;

  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
    .pc_update(pc_update), .branch(branch), .reg_write(reg_write),
    .mem_write(mem_write), .ir_write(ir_write), .adr_src(adr_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .result_src(result_src), .state(state), .instret(instret),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; op = OP_SW; mem_ready = 1'b1;
    #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (instret !== 4'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
    checks++; if ({pc_update, ir_write} !== 2'b00) begin errors++; $display("FAIL reset_gated_en: got %b expected 00", {pc_update, ir_write}); end
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", illegal_op); end
    @(negedge clk); reset = 1'b1; #1;
    checks++; if (ir_write !== 1'b1) begin errors++; $display("FAIL fetch_after_release: ir_write got %b expected 1", ir_write); end
    tick();
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL first_decode: got %0d expected 1", state); end
    mem_ready = 1'b0;
    tick(); tick();
    checks++; if (state !== 4'd5 || mem_write !== 1'b1) begin errors++; $display("FAIL pre_abort: state %0d mem_write %b expected 5/1", state, mem_write); end
    reset = 1'b0; #1;
    checks++; if (state !== 4'd0 || mem_write !== 1'b0) begin errors++; $display("FAIL abort: state %0d mem_write %b expected 0/0", state, mem_write); end
    checks++; if (instret !== 4'd0) begin errors++; $display("FAIL abort_instret: got %0d expected 0", instret); end
    @(negedge clk); reset = 1'b1; mem_ready = 1'b1; #1;
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL release_fetch: got %0d expected 0", state); end
    tick();
    checks++; if (state !== 4'd1) begin errors++; $display("FAIL release_decode: got %0d expected 1", state); end
  endtask

  task automatic test_lw();
    logic [3:0] exp_s [5];
    exp_s = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    pulse_reset(); op = OP_LW; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
      checks++; if (reg_write !== (exp_s[i] == 4'd4)) begin errors++; $display("FAIL lw_reg_write[%0d]: got %b", i, reg_write); end
      if (exp_s[i] == 4'd4) begin
        checks++; if (result_src !== 2'b01) begin errors++; $display("FAIL lw_result_src: got %b expected 01", result_src); end
      end
      if (exp_s[i] == 4'd3) begin
        checks++; if (adr_src !== 1'b1) begin errors++; $display("FAIL lw_adr_src: got %b expected 1", adr_src); end
      end
    end
    checks++; if (instret !== 4'd1) begin errors++; $display("FAIL lw_instret: got %0d expected 1", instret); end
  endtask

  task automatic test_sw_wait();
    int wr_cycles = 0;
    pulse_reset(); op = OP_SW; mem_ready = 1'b1;
    tick(); tick();
    checks++; if (state !== 4'd2 || alu_src_a !== 2'b10 || alu_src_b !== 2'b01) begin errors++; $display("FAIL sw_memadr: state %0d a %b b %b", state, alu_src_a, alu_src_b); end
    mem_ready = 1'b0;
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) mem_ready = 1'b1;
      #1;
      if (state == 4'd5 && mem_write == 1'b1) wr_cycles++;
      if (k < 3) begin
        checks++; if (instret !== 4'd0) begin errors++; $display("FAIL sw_instret_hold[%0d]: got %0d expected 0", k, instret); end
      end
      tick();
    end
    checks++; if (wr_cycles !== 4) begin errors++; $display("FAIL sw_mem_write_cycles: got %0d expected 4", wr_cycles); end
    checks++; if (state !== 4'd0 || mem_write !== 1'b0) begin errors++; $display("FAIL sw_done: state %0d mem_write %b expected 0/0", state, mem_write); end
    checks++; if (instret !== 4'd1) begin errors++; $display("FAIL sw_instret: got %0d expected 1", instret); end
  endtask

  task automatic test_r_beq();
    logic [3:0] exp_s [7];
    int br_cycles = 0;
    exp_s = '{4'd1, 4'd6, 4'd9, 4'd0, 4'd1, 4'd10, 4'd0};
    pulse_reset(); op = OP_R; mem_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 1) op = OP_LW;   // late op change must not redirect EXECR
      if (i == 3) op = OP_BEQ;
      #1;
      checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL rbeq_state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
      if (branch === 1'b1) begin
        br_cycles++;
        checks++; if (alu_op !== 2'b01) begin errors++; $display("FAIL beq_alu_op: got %b expected 01", alu_op); end
      end
      if (exp_s[i] == 4'd6) begin
        checks++; if (alu_op !== 2'b10 || alu_src_b !== 2'b00) begin errors++; $display("FAIL execr_dec: alu_op %b b %b", alu_op, alu_src_b); end
      end
    end
    checks++; if (br_cycles !== 1) begin errors++; $display("FAIL beq_branch_cycles: got %0d expected 1", br_cycles); end
    checks++; if (instret !== 4'd2) begin errors++; $display("FAIL rbeq_instret: got %0d expected 2", instret); end
  endtask

  task automatic test_fetch_stall();
    pulse_reset(); op = OP_BEQ; mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if (state !== 4'd0 || ir_write !== 1'b0 || pc_update !== 1'b0) begin errors++; $display("FAIL stall[%0d]: state %0d ir %b pc %b expected 0/0/0", i, state, ir_write, pc_update); end
      tick();
    end
    mem_ready = 1'b1; #1;
    checks++; if (ir_write !== 1'b1 || pc_update !== 1'b1) begin errors++; $display("FAIL stall_release: ir %b pc %b expected 1/1", ir_write, pc_update); end
    tick();
    checks++; if (state !== 4'd1 || ir_write !== 1'b0 || pc_update !== 1'b0) begin errors++; $display("FAIL stall_decode: state %0d ir %b pc %b expected 1/0/0", state, ir_write, pc_update); end
  endtask

  task automatic test_illegal();
    pulse_reset(); op = OP_BAD; mem_ready = 1'b1;
    tick(); tick();
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      checks++; if (state !== 4'd11 || illegal_op !== 1'b1) begin errors++; $display("FAIL trap[%0d]: state %0d illegal %b expected 11/1", i, state, illegal_op); end
      checks++; if ({pc_update, ir_write, reg_write, mem_write, branch} !== 5'b0) begin errors++; $display("FAIL trap_en[%0d]: got %b expected 00000", i, {pc_update, ir_write, reg_write, mem_write, branch}); end
      tick();
    end
    checks++; if (instret !== 4'd0) begin errors++; $display("FAIL trap_instret: got %0d expected 0", instret); end
    pulse_reset(); #1;
    checks++; if (state !== 4'd0 || illegal_op !== 1'b0) begin errors++; $display("FAIL trap_exit: state %0d illegal %b expected 0/0", state, illegal_op); end
`else
    checks++; if (state !== 4'd0 || illegal_op !== 1'b0) begin errors++; $display("FAIL illegal_back: state %0d illegal %b expected 0/0", state, illegal_op); end
    checks++; if (instret !== 4'd0) begin errors++; $display("FAIL illegal_instret: got %0d expected 0", instret); end
`endif
  endtask

  task automatic test_wrap();
    logic [3:0] exp_s [4];
    exp_s = '{4'd1, 4'd8, 4'd9, 4'd0};
    pulse_reset(); op = OP_BEQ; mem_ready = 1'b1;
    for (int i = 0; i < 45; i++) tick();
    checks++; if (instret !== 4'hF || state !== 4'd0) begin errors++; $display("FAIL preload: instret %0d state %0d expected 15/0", instret, state); end
    op = OP_JAL;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (state !== exp_s[i]) begin errors++; $display("FAIL jal_state[%0d]: got %0d expected %0d", i, state, exp_s[i]); end
      if (exp_s[i] == 4'd8) begin
        checks++; if (pc_update !== 1'b1 || alu_src_a !== 2'b01 || alu_src_b !== 2'b10) begin errors++; $display("FAIL jal_dec: pc %b a %b b %b", pc_update, alu_src_a, alu_src_b); end
      end
    end
    checks++; if (instret !== 4'd0) begin errors++; $display("FAIL wrap: got %0d expected 0", instret); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_r_beq();
    test_fetch_stall();
    test_illegal();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Main control FSM for the multi-cycle RISC-V core. It sequences each instruction through fetch, decode, execute, memory and writeback. It drives the write enables that feed the PC, instruction, data and ALU-result flip-flop registers, plus the datapath mux selects. It consumes the opcode from the instruction register and a memory ready handshake. It also provides a retired-instruction counter.

Parameters:
CNT_W, 32, width of instret counter

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (asserted when 0)
op  input  7  opcode field of the instruction register (instr[6:0])
mem_ready  input  1  memory has completed the current access this cycle
pc_update  output  1  PC register write enable (unconditional)
branch  output  1  branch-qualify strobe; datapath ANDs it with zero flag
reg_write  output  1  register-file write enable
mem_write  output  1  data-memory write request
ir_write  output  1  instruction register and old-PC register write enable
adr_src  output  1  memory address: 0=PC, 1=result
alu_src_a  output  2  00=PC, 01=oldPC, 10=rs1 reg
alu_src_b  output  2  00=rs2 reg, 01=imm_ext, 10=constant 4
alu_op  output  2  00=add, 01=sub, 10=decode by funct
result_src  output  2  00=ALUOut reg, 01=data reg, 10=ALU result
state  output  4  current state code (debug)
instret  output  CNT_W  retired-instruction count
illegal_op  output  1  trap indicator (see Optional Feature)

Behaviour:
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, JAL 8, ALUWB 9, BEQ 10, TRAP 11.
- Reset low: state=FETCH and instret=0 immediately, without waiting for a clock edge. While reset is low, pc_update/ir_write/reg_write/mem_write/branch are forced to 0. illegal_op=0.
- On reset release, the first rising edge evaluates FETCH normally.
- Moore decode from state. Every output not listed for a state is 0.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write and pc_update = mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00. Next state by op:
  - 0000011 (lw) or 0100011 (sw) -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - other -> see Optional Feature
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Go to MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Wait for mem_ready, then -> MEMWB.
- MEMWB: result_src=01, reg_write=1 -> FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1. Hold until mem_ready, then -> FETCH. mem_write stays high until the cycle mem_ready is seen.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALUWB.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1 -> ALUWB.
- ALUWB: result_src=00, reg_write=1 -> FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1 -> FETCH.
- instret increments by 1 on the edge leaving MEMWB, MEMWRITE (with mem_ready), ALUWB or BEQ. It wraps modulo 2^CNT_W.
- Cycle counts with mem_ready held 1:
  - lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3.
  - Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- op is sampled only in DECODE and MEMADR. Changes in op at other times have no effect.
- Reset asserted mid-instruction aborts it with no instret increment.
- Unused state codes 12-15 go to FETCH on the next edge with all enables 0.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined: an unknown op in DECODE goes to TRAP. In TRAP, all enables are 0 and illegal_op=1. TRAP is sticky; only reset exits it. instret is frozen.
- Undefined: an unknown op in DECODE returns to FETCH with no instret increment. TRAP is unreachable and illegal_op is tied 0.

Test Plan:
- Reset low mid-MEMWRITE with mem_write=1 -> state=0 and mem_write=0 the same cycle; instret=0; first FETCH after release.
- lw (op=0000011), mem_ready=1 -> states 0,1,2,3,4,0; reg_write only in state 4 with result_src=01; instret 0->1.
- sw, mem_ready low 3 cycles in MEMWRITE -> mem_write high for 4 cycles, then FETCH; instret +1.
- R-type then beq -> states 0,1,6,9 then 0,1,10; branch=1 with alu_op=01 exactly one cycle; instret=2.
- FETCH with mem_ready low 2 cycles -> ir_write/pc_update 0 for 2 cycles, then 1 for exactly one cycle.
- op=1111111: with the macro, state=11 and illegal_op=1 held for 10 cycles until reset; without it, back to FETCH with instret unchanged.
- instret preloaded to all-ones (CNT_W=4, 15 instructions) then jal -> instret wraps to 0.
